// File: rtl/fp_pkg.sv
// Shared floating-point package: FSM state, operand classes, exception flag
// bundle and constant-word helpers parameterised by exponent/mantissa width.
// Intended to be shared by the FP divider and the FP multiplier.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
        logic nan;
    } fp_flags_t;

    // Exponent field all ones, sign and mantissa clear (infinity magnitude).
    function automatic logic [63:0] exp_ones_word(input int unsigned e, input int unsigned m);
        return ((64'd1 << e) - 64'd1) << m;
    endfunction

    // Quiet NaN: positive, exponent all ones, mantissa MSB set.
    function automatic logic [63:0] qnan_word(input int unsigned e, input int unsigned m);
        return exp_ones_word(e, m) | (64'd1 << (m - 1));
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier (combinational).
// Ports:
//   mag        in   E+M  operand without its sign bit {exp, man}
//   op_class_c out  2    zero (denormals flushed), normal, infinity or NaN
module fp_classify import fp_pkg::*; #(
    parameter int unsigned E = 8,
    parameter int unsigned M = 23
) (
    input  logic [E+M-1:0] mag,
    output fp_class_t      op_class_c
);

    logic [E-1:0] ex;
    logic [M-1:0] mn;

    assign ex = mag[E+M-1:M];
    assign mn = mag[M-1:0];

    always_comb begin
        op_class_c = FP_NORM;
        if (ex == '0) begin
            op_class_c = FP_ZERO;
        end else if (ex == '1) begin
            op_class_c = (mn == '0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Iterative floating-point divider, result = X / Y, restoring division one
// quotient bit per clock. Truncating by default; defining FP_DIV_ROUND_EN
// adds a guard iteration and round-to-nearest-even.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   X, Y                 dividend, divisor {sign, exp, man}
//   out_valid/out_ready  result handshake; result held until accepted
//   result               quotient word
//   zero, underflow, overflow, nan  exception flags, valid with out_valid
module fp_divider import fp_pkg::*; #(
    parameter int unsigned E = 8,
    parameter int unsigned M = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] X,
    input  logic [E+M:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] result,
    output logic         zero,
    output logic         underflow,
    output logic         overflow,
    output logic         nan
);

    localparam int unsigned BITS = 1 + M + E;
    localparam int unsigned EB   = (1 << (E - 1)) - 1;
    localparam int unsigned EW   = E + 2;
`ifdef FP_DIV_ROUND_EN
    localparam int unsigned ITERS = M + 3;
`else
    localparam int unsigned ITERS = M + 2;
`endif
    localparam int unsigned CW = $clog2(ITERS + 1);

    localparam logic [BITS-1:0]      QNAN      = BITS'(qnan_word(E, M));
    localparam logic [BITS-1:0]      EXP_ONES  = BITS'(exp_ones_word(E, M));
    localparam logic signed [EW-1:0] EXP_ZERO  = '0;
    localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << E) - 1);

    fp_class_t x_cls, y_cls;

    fp_classify #(.E(E), .M(M)) u_class_x (.mag(X[BITS-2:0]), .op_class_c(x_cls));
    fp_classify #(.E(E), .M(M)) u_class_y (.mag(Y[BITS-2:0]), .op_class_c(y_cls));

    state_t                state;
    logic [M+1:0]          rem;
    logic [M:0]            ym;
    logic [ITERS-1:0]      q;
    logic [CW-1:0]         cnt;
    logic signed [EW-1:0]  e_q;
    logic                  sgn;

    logic                  sign_in;
    logic                  spec_hit_c;
    logic [BITS-1:0]       spec_res_c;
    fp_flags_t             spec_flags_c;

    logic                  ge_c;
    logic [M+1:0]          trial_c;

    logic [M-1:0]          man_c;
    logic signed [EW-1:0]  exp_c;
    logic [BITS-1:0]       norm_res_c;
    fp_flags_t             norm_flags_c;
`ifdef FP_DIV_ROUND_EN
    logic                  guard_c;
    logic                  sticky_c;
    logic                  carry_c;
`endif

    assign sign_in = X[BITS-1] ^ Y[BITS-1];

    // Special operands resolve at accept, in priority order NaN, overflow, zero.
    always_comb begin
        spec_hit_c   = 1'b1;
        spec_res_c   = '0;
        spec_flags_c = '0;
        if (x_cls == FP_NAN || y_cls == FP_NAN ||
            (x_cls == FP_ZERO && y_cls == FP_ZERO) ||
            (x_cls == FP_INF && y_cls == FP_INF)) begin
            spec_flags_c.nan = 1'b1;
            spec_res_c       = QNAN;
        end else if (x_cls == FP_INF || y_cls == FP_ZERO) begin
            spec_flags_c.overflow = 1'b1;
            spec_res_c            = {sign_in, {(BITS-1){1'b0}}} | EXP_ONES;
        end else if (x_cls == FP_ZERO || y_cls == FP_INF) begin
            spec_flags_c.zero = 1'b1;
            spec_res_c        = {sign_in, {(BITS-1){1'b0}}};
        end else begin
            spec_hit_c = 1'b0;
        end
    end

    // One restoring-division step: subtract divisor when it fits.
    assign ge_c    = (rem >= {1'b0, ym});
    assign trial_c = ge_c ? (rem - {1'b0, ym}) : rem;

    // Normalise the quotient, optionally round, then range-check the exponent.
    always_comb begin
        man_c        = '0;
        exp_c        = e_q;
        norm_res_c   = '0;
        norm_flags_c = '0;
        if (q[ITERS-1]) begin
            man_c = q[ITERS-2 -: M];
        end else begin
            man_c = q[ITERS-3 -: M];
            exp_c = e_q - EXP_ONE;
        end
`ifdef FP_DIV_ROUND_EN
        guard_c  = 1'b0;
        sticky_c = 1'b0;
        carry_c  = 1'b0;
        if (q[ITERS-1]) begin
            guard_c  = q[1];
            sticky_c = q[0] | (|rem);
        end else begin
            guard_c  = q[0];
            sticky_c = |rem;
        end
        {carry_c, man_c} = {1'b0, man_c} + (M+1)'(guard_c & (sticky_c | man_c[0]));
        if (carry_c) begin
            exp_c = exp_c + EXP_ONE;
        end
`endif
        if (exp_c <= EXP_ZERO) begin
            norm_flags_c.underflow = 1'b1;
            norm_flags_c.zero      = 1'b1;
            norm_res_c             = {sgn, {(BITS-1){1'b0}}};
        end else if (exp_c >= EXP_MAX) begin
            norm_flags_c.overflow = 1'b1;
            norm_res_c            = {sgn, {(BITS-1){1'b0}}} | EXP_ONES;
        end else begin
            norm_res_c = {sgn, exp_c[E-1:0], man_c};
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            nan       <= 1'b0;
            rem       <= '0;
            ym        <= '0;
            q         <= '0;
            cnt       <= '0;
            e_q       <= '0;
            sgn       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sgn      <= sign_in;
                        e_q      <= EW'(X[BITS-2:M]) - EW'(Y[BITS-2:M]) + EW'(EB);
                        rem      <= {1'b0, 1'b1, X[M-1:0]};
                        ym       <= {1'b1, Y[M-1:0]};
                        q        <= '0;
                        cnt      <= '0;
                        if (spec_hit_c) begin
                            result    <= spec_res_c;
                            zero      <= spec_flags_c.zero;
                            underflow <= spec_flags_c.underflow;
                            overflow  <= spec_flags_c.overflow;
                            nan       <= spec_flags_c.nan;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    q   <= {q[ITERS-2:0], ge_c};
                    rem <= trial_c << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result    <= norm_res_c;
                    zero      <= norm_flags_c.zero;
                    underflow <= norm_flags_c.underflow;
                    overflow  <= norm_flags_c.overflow;
                    nan       <= norm_flags_c.nan;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        result    <= '0;
                        zero      <= 1'b0;
                        underflow <= 1'b0;
                        overflow  <= 1'b0;
                        nan       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Testbench for fp_divider (E=8, M=23): directed spec vectors, backpressure,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_fp_divider;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] X;
    logic [31:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        underflow;
    logic        overflow;
    logic        nan;

    int total = 0;
    int bad   = 0;

`ifdef FP_DIV_ROUND_EN
    localparam int NL = 27;
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam int NL = 26;
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    fp_divider #(.E(8), .M(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .underflow (underflow),
        .overflow  (overflow),
        .nan       (nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of the significands, then normalise/round.
    function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        int          xe, ye, e;
        logic        s, xz, yz, xi, yi, xn, yn, g, st;
        logic [63:0] xm, ym, num, qq, rm, frac;
        xe = int'(x[30:23]);
        ye = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (xe == 0);
        yz = (ye == 0);
        xi = (xe == 255) && (x[22:0] == 23'd0);
        yi = (ye == 255) && (y[22:0] == 23'd0);
        xn = (xe == 255) && (x[22:0] != 23'd0);
        yn = (ye == 255) && (y[22:0] != 23'd0);
        if (xn || yn || (xz && yz) || (xi && yi)) return {4'b0001, 32'h7FC00000};
        if (xi || yz) return {4'b0010, s, 31'h7F800000};
        if (xz || yi) return {4'b1000, s, 31'd0};
        xm  = 64'h800000 | 64'(x[22:0]);
        ym  = 64'h800000 | 64'(y[22:0]);
        num = xm << 25;
        qq  = num / ym;
        rm  = num % ym;
        e   = xe - ye + 127;
        if (qq >= (64'd1 << 25)) begin
            frac = qq >> 2;
            g    = qq[1];
            st   = qq[0] || (rm != 0);
        end else begin
            e    = e - 1;
            frac = qq >> 1;
            g    = qq[0];
            st   = (rm != 0);
        end
`ifdef FP_DIV_ROUND_EN
        if (g && (st || frac[0])) frac = frac + 64'd1;
        if (frac == (64'd1 << 24)) begin
            frac = 64'd1 << 23;
            e    = e + 1;
        end
`else
        if (g && st) frac = frac;
`endif
        if (e <= 0) return {4'b1100, s, 31'd0};
        if (e >= 255) return {4'b0010, s, 31'h7F800000};
        return {4'b0000, s, 8'(e), frac[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = int'($urandom_range(0, 11));
        if (k == 0) begin
            v[30:23] = 8'h00;
        end else if (k == 1) begin
            v[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) v[22:0] = '0;
        end else if (k < 7) begin
            v[30:23] = 8'($urandom_range(100, 154));
        end else begin
            v[30:23] = 8'($urandom_range(1, 254));
        end
        return v;
    endfunction

    // Issue one operation, wait for the result, hold it for 'hold' cycles, accept it.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        check("accept_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        X        = x;
        Y        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("timeout", 64'(out_valid), 64'(1));
        r = result;
        f = {zero, underflow, overflow, nan};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_result", 64'(result), 64'(r));
            check("hold_flags", 64'({zero, underflow, overflow, nan}), 64'(f));
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("clr_valid", 64'(out_valid), 64'(0));
        check("clr_result", 64'({result, zero, underflow, overflow, nan}), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));
    endtask

    logic [31:0] dx [8];
    logic [31:0] dy [8];
    logic [31:0] dr [8];
    logic [3:0]  df [8];
    int          dl [8];

    initial begin
        logic [31:0] r, x, y;
        logic [3:0]  f;
        logic [35:0] m;
        int          lat, seen;

        // {zero, underflow, overflow, nan}
        dx[0] = 32'h40C00000; dy[0] = 32'h40000000; dr[0] = 32'h40400000; df[0] = 4'b0000; dl[0] = NL;
        dx[1] = 32'h3F800000; dy[1] = 32'h40400000; dr[1] = THIRD;        df[1] = 4'b0000; dl[1] = NL;
        dx[2] = 32'hC1000000; dy[2] = 32'h3F000000; dr[2] = 32'hC1800000; df[2] = 4'b0000; dl[2] = NL;
        dx[3] = 32'h3F800000; dy[3] = 32'h00000000; dr[3] = 32'h7F800000; df[3] = 4'b0010; dl[3] = 0;
        dx[4] = 32'h00000000; dy[4] = 32'h00000000; dr[4] = 32'h7FC00000; df[4] = 4'b0001; dl[4] = 0;
        dx[5] = 32'h00800000; dy[5] = 32'h40000000; dr[5] = 32'h00000000; df[5] = 4'b1100; dl[5] = NL;
        dx[6] = 32'hFF800000; dy[6] = 32'h7F800000; dr[6] = 32'h7FC00000; df[6] = 4'b0001; dl[6] = 0;
        dx[7] = 32'h00000000; dy[7] = 32'hFF800000; dr[7] = 32'h80000000; df[7] = 4'b1000; dl[7] = 0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        Y         = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_result", 64'({result, zero, underflow, overflow, nan}), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_op(dx[i], dy[i], 0, r, f, lat);
            check($sformatf("dir%0d_result", i), 64'(r), 64'(dr[i]));
            check($sformatf("dir%0d_flags", i), 64'(f), 64'(df[i]));
            check($sformatf("dir%0d_latency", i), 64'(lat), 64'(dl[i]));
        end

        // Backpressure on an overflowing normal-path result.
        run_op(32'h7F000000, 32'h3F000000, 5, r, f, lat);
        check("bp_result", 64'(r), 64'h7F800000);
        check("bp_flags", 64'(f), 64'(4'b0010));

        // Reset in the middle of the iteration phase discards the operation.
        in_valid = 1'b1;
        X        = 32'h40C00000;
        Y        = 32'h40000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_emit", 64'(seen), 64'(0));
        run_op(32'h40C00000, 32'h40000000, 0, r, f, lat);
        check("midrst_after_result", 64'(r), 64'h40400000);
        check("midrst_after_flags", 64'(f), 64'(0));

        // Randomized operands against the model.
        for (int i = 0; i < 40; i++) begin
            x = rand_op();
            y = rand_op();
            m = ref_div(x, y);
            run_op(x, y, int'($urandom_range(0, 2)), r, f, lat);
            check($sformatf("rnd%0d_%08h_%08h", i, x, y), 64'({f, r}), 64'(m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
